// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - shared config field offsets and sequencer state encoding
package coproc_pkg;

  localparam int MU_LSB     = 16;
  localparam int GAMMA_LSB  = 8;
  localparam int LAMBDA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    CFG_READ,
    CFG_WAIT,
    DISPATCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant held while requested
module rr_arbiter #(
  parameter int channels = 2
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_enable,
  input  logic [channels-1:0] in_request,
  output logic [channels-1:0] out_grant
);

  localparam int PW = (channels > 1) ? $clog2(channels) : 1;

  logic [channels-1:0] r_grant;
  logic [PW-1:0]       r_ptr;
  logic [channels-1:0] w_next;
  logic [PW-1:0]       w_next_ptr;
  logic                w_found;
  logic                w_hold;

  assign w_hold    = |(r_grant & in_request);
  assign out_grant = r_grant;

  // r_ptr names the channel searched first: the one after the last winner.
  always_comb begin
    int idx;
    w_next     = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    idx        = 0;
    for (int off = 0; off < channels; off++) begin
      idx = (int'(r_ptr) + off) % channels;
      if (!w_found && in_request[idx]) begin
        w_found     = 1'b1;
        w_next[idx] = 1'b1;
        w_next_ptr  = PW'((idx + 1) % channels);
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (!in_enable) begin
      r_grant <= '0;
    end else if (!w_hold) begin
      r_grant <= w_next;
      if (w_found) r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/coproc_job_dispatcher.sv
// rtl/coproc_job_dispatcher.sv - reads the job config, dispatches (row,col) indices to
// processor channels and arbitrates the shared memory port among them
module coproc_job_dispatcher
  import coproc_pkg::*;
#(
  parameter int channels        = 2,
  parameter int index_width     = 8,
  parameter int cell_width      = 32,
  parameter int width           = 96,
  parameter int memory_size_log = 8,
  parameter int config_address  = 0
) (
  input  logic                                 in_clk,
  input  logic                                 in_reset,
  input  logic                                 in_start,
  output logic                                 out_busy,
  output logic                                 out_done,
  output logic [cell_width-1:0]                out_config,
  output logic [channels*index_width-1:0]      out_row_index,
  output logic [channels*index_width-1:0]      out_col_index,
  output logic [channels*index_width-1:0]      out_mu,
  output logic [channels-1:0]                  out_index_ready,
  input  logic [channels-1:0]                  in_result_ready,
  input  logic [channels-1:0]                  in_request,
  output logic [channels-1:0]                  out_grant,
  input  logic [channels-1:0]                  in_ch_mem_read_en,
  input  logic [channels-1:0]                  in_ch_mem_write_en,
  input  logic [channels*memory_size_log-1:0]  in_ch_mem_address,
  input  logic [channels*width-1:0]            in_ch_mem_data,
  output logic [width-1:0]                     out_ch_mem_data,
  output logic [memory_size_log-1:0]           out_mem_address,
  output logic [width-1:0]                     out_mem_data,
  output logic                                 out_mem_read_en,
  output logic                                 out_mem_write_en,
  input  logic [width-1:0]                     in_mem_data
);

  localparam int JW = 2 * index_width;
  localparam logic [index_width-1:0] IDX_ONE = 1;
  localparam logic [JW-1:0]          JOB_ONE = 1;

  state_t                           r_state;
  logic                             r_busy;
  logic                             r_done;
  logic [cell_width-1:0]            r_config;
  logic [JW-1:0]                    r_issued;
  logic [JW-1:0]                    r_total;
  logic [index_width-1:0]           r_row;
  logic [index_width-1:0]           r_col;
  logic [channels-1:0]              r_index_ready;
  logic [channels-1:0]              r_rest;
  logic [channels*index_width-1:0]  r_row_index;
  logic [channels*index_width-1:0]  r_col_index;
  logic [channels*index_width-1:0]  r_mu;

  logic [channels-1:0]              w_idle;
  logic [channels-1:0]              w_pick;
  logic                             w_free_found;
  logic                             w_issue;
  logic                             w_arb_en;
  logic [channels-1:0]              w_grant_raw;
  logic [channels-1:0]              w_grant;
  logic [index_width-1:0]           w_mem_lambda;
  logic [index_width-1:0]           w_mem_gamma;
  logic [index_width-1:0]           w_cfg_gamma;
  logic [index_width-1:0]           w_cfg_mu;

  assign w_mem_lambda = in_mem_data[LAMBDA_LSB +: index_width];
  assign w_mem_gamma  = in_mem_data[GAMMA_LSB +: index_width];
  assign w_cfg_gamma  = r_config[GAMMA_LSB +: index_width];
  assign w_cfg_mu     = r_config[MU_LSB +: index_width];

  assign w_idle  = ~r_index_ready & ~r_rest;
  assign w_issue = (r_state == DISPATCH) && w_free_found;

  // Descending scan so the lowest-numbered idle channel is the one left in w_pick.
  always_comb begin
    w_pick       = '0;
    w_free_found = 1'b0;
    for (int k = channels - 1; k >= 0; k--) begin
      if (w_idle[k]) begin
        w_pick       = '0;
        w_pick[k]    = 1'b1;
        w_free_found = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_config      <= '0;
      r_issued      <= '0;
      r_total       <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_index_ready <= '0;
      r_rest        <= '0;
      r_row_index   <= '0;
      r_col_index   <= '0;
      r_mu          <= '0;
    end else begin
      r_done <= 1'b0;
      for (int k = 0; k < channels; k++) begin
        r_rest[k] <= r_index_ready[k] & in_result_ready[k];
        if (r_index_ready[k] && in_result_ready[k]) begin
          r_index_ready[k] <= 1'b0;
        end else if (w_issue && w_pick[k]) begin
          r_index_ready[k]                      <= 1'b1;
          r_row_index[k*index_width +: index_width] <= r_row;
          r_col_index[k*index_width +: index_width] <= r_col;
          r_mu[k*index_width +: index_width]        <= w_cfg_mu;
        end
      end

      case (r_state)
        IDLE: begin
          if (in_start) begin
            r_state  <= CFG_READ;
            r_busy   <= 1'b1;
            r_issued <= '0;
            r_row    <= '0;
            r_col    <= '0;
          end
        end
        CFG_READ: r_state <= CFG_WAIT;
        CFG_WAIT: begin
          r_config <= in_mem_data[cell_width-1:0];
          r_total  <= JW'(w_mem_lambda) * JW'(w_mem_gamma);
          if (w_mem_lambda == '0 || w_mem_gamma == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (w_issue) begin
            r_issued <= r_issued + JOB_ONE;
            if ((r_col + IDX_ONE) == w_cfg_gamma) begin
              r_col <= '0;
              r_row <= r_row + IDX_ONE;
            end else begin
              r_col <= r_col + IDX_ONE;
            end
            if ((r_issued + JOB_ONE) == r_total) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (&w_idle) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The sequencer owns the memory port while fetching the config word.
  assign w_arb_en = (r_state != CFG_READ) && (r_state != CFG_WAIT);
  assign w_grant  = w_grant_raw & {channels{w_arb_en}};

  rr_arbiter #(
    .channels (channels)
  ) u_arbiter (
    .in_clk     (in_clk),
    .in_reset   (in_reset),
    .in_enable  (w_arb_en),
    .in_request (in_request),
    .out_grant  (w_grant_raw)
  );

  always_comb begin
    out_mem_address  = '0;
    out_mem_data     = '0;
    out_mem_read_en  = 1'b0;
    out_mem_write_en = 1'b0;
    if (r_state == CFG_READ) begin
      out_mem_read_en = 1'b1;
      out_mem_address = memory_size_log'(config_address);
    end else begin
      for (int k = 0; k < channels; k++) begin
        if (w_grant[k]) begin
          out_mem_address  = in_ch_mem_address[k*memory_size_log +: memory_size_log];
          out_mem_data     = in_ch_mem_data[k*width +: width];
          out_mem_write_en = in_ch_mem_write_en[k];
          out_mem_read_en  = in_ch_mem_read_en[k] & ~in_ch_mem_write_en[k];
        end
      end
    end
  end

  assign out_busy        = r_busy;
  assign out_done        = r_done;
  assign out_config      = r_config;
  assign out_row_index   = r_row_index;
  assign out_col_index   = r_col_index;
  assign out_mu          = r_mu;
  assign out_index_ready = r_index_ready;
  assign out_grant       = w_grant;
  assign out_ch_mem_data = in_mem_data;

endmodule

// File: tb/tb_coproc_job_dispatcher.sv
// tb/tb_coproc_job_dispatcher.sv - scoreboard bench: expected jobs from config, monitor pops on index_ready
module tb_coproc_job_dispatcher;
  localparam int CH = 2, IW = 8, CW = 32, W = 96, ML = 8;

  logic              in_clk = 1'b0;
  logic              in_reset = 1'b0;
  logic              in_start = 1'b0;
  logic              out_busy, out_done;
  logic [CW-1:0]     out_config;
  logic [CH*IW-1:0]  out_row_index, out_col_index, out_mu;
  logic [CH-1:0]     out_index_ready, out_grant;
  logic [CH-1:0]     in_result_ready;
  logic [CH-1:0]     in_request = '0;
  logic [CH-1:0]     in_ch_mem_read_en = '0;
  logic [CH-1:0]     in_ch_mem_write_en = '0;
  logic [CH*ML-1:0]  in_ch_mem_address = '0;
  logic [CH*W-1:0]   in_ch_mem_data = '0;
  logic [W-1:0]      out_ch_mem_data, out_mem_data, in_mem_data;
  logic [ML-1:0]     out_mem_address;
  logic              out_mem_read_en, out_mem_write_en;

  coproc_job_dispatcher #(
    .channels(CH), .index_width(IW), .cell_width(CW), .width(W),
    .memory_size_log(ML), .config_address(0)
  ) dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
    .out_busy(out_busy), .out_done(out_done), .out_config(out_config),
    .out_row_index(out_row_index), .out_col_index(out_col_index), .out_mu(out_mu),
    .out_index_ready(out_index_ready), .in_result_ready(in_result_ready),
    .in_request(in_request), .out_grant(out_grant),
    .in_ch_mem_read_en(in_ch_mem_read_en), .in_ch_mem_write_en(in_ch_mem_write_en),
    .in_ch_mem_address(in_ch_mem_address), .in_ch_mem_data(in_ch_mem_data),
    .out_ch_mem_data(out_ch_mem_data), .out_mem_address(out_mem_address),
    .out_mem_data(out_mem_data), .out_mem_read_en(out_mem_read_en),
    .out_mem_write_en(out_mem_write_en), .in_mem_data(in_mem_data)
  );

  always #5 in_clk = ~in_clk;

  logic [W-1:0] mem [256];
  logic [W-1:0] mem_q = '0;
  always @(posedge in_clk) begin
    if (out_mem_write_en) mem[out_mem_address] <= out_mem_data;
    if (out_mem_read_en) mem_q <= mem[out_mem_address];
  end
  assign in_mem_data = mem_q;

  logic res_q [CH];
  always_comb for (int k = 0; k < CH; k++) in_result_ready[k] = res_q[k];

  typedef struct {int row; int col; int mu; int ch;} job_t;
  job_t exp_q[$];
  int n_cmp = 0, n_fail = 0, n_done = 0, n_issued = 0, fixed_lat = 5;
  logic [CH-1:0] prev_rdy = '0;
  logic prev_done = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endfunction

  // Monitor: each rising index_ready is one dispatched job, matched in order.
  always @(negedge in_clk) begin
    job_t j;
    if (in_reset) begin
      for (int k = 0; k < CH; k++) begin
        if (out_index_ready[k] && !prev_rdy[k]) begin
          n_issued++;
          if (exp_q.size() == 0) begin
            chk("unexpected_job", 1, 0);
          end else begin
            j = exp_q.pop_front();
            chk("job_row", int'(out_row_index[k*IW +: IW]), j.row);
            chk("job_col", int'(out_col_index[k*IW +: IW]), j.col);
            chk("job_mu", int'(out_mu[k*IW +: IW]), j.mu);
            if (j.ch >= 0) chk("job_channel", k, j.ch);
          end
        end
      end
      if (out_done) begin
        n_done++;
        chk("done_width", int'(prev_done), 0);
        chk("busy_at_done", int'(out_busy), 0);
      end
    end
    prev_rdy  = out_index_ready;
    prev_done = out_done;
  end

  task automatic chan_model(int k);
    int lat;
    forever begin
      @(negedge in_clk);
      if (in_reset && out_index_ready[k]) begin
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        for (int n = 0; n < lat; n++) begin
          @(negedge in_clk);
          if (!in_reset) break;
        end
        if (in_reset) begin
          res_q[k] = 1'b1;
          @(negedge in_clk);
          res_q[k] = 1'b0;
        end
      end
    end
  endtask

  for (genvar g = 0; g < CH; g++) begin : g_ch
    initial chan_model(g);
  end

  task automatic tick(int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic push_jobs(int cfg, bit check_ch);
    int lambda, gamma, mu, idx;
    lambda = cfg & 255;
    gamma  = (cfg >> 8) & 255;
    mu     = (cfg >> 16) & 255;
    idx    = 0;
    for (int i = 0; i < lambda; i++)
      for (int c = 0; c < gamma; c++) begin
        exp_q.push_back('{i, c, mu, check_ch ? idx % CH : -1});
        idx++;
      end
  endtask

  task automatic pulse_start();
    @(negedge in_clk); in_start = 1'b1;
    @(negedge in_clk); in_start = 1'b0;
  endtask

  task automatic wait_done(int d0, int budget);
    int n;
    n = 0;
    while (n_done == d0 && n < budget) begin
      @(negedge in_clk);
      n++;
    end
  endtask

  task automatic run_job(int cfg, bit check_ch, int budget);
    int d0;
    mem[0] = {64'hA5A5_5A5A_1234_5678, 32'(cfg)};
    push_jobs(cfg, check_ch);
    d0 = n_done;
    pulse_start();
    wait_done(d0, budget);
    tick(3);
    chk("done_count", n_done - d0, 1);
    chk("jobs_left", exp_q.size(), 0);
    chk("config_latched", int'(out_config), cfg);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, int'(out_busy), 0);
    chk({tag, "_done"}, int'(out_done), 0);
    chk({tag, "_index_ready"}, int'(out_index_ready), 0);
    chk({tag, "_grant"}, int'(out_grant), 0);
    chk({tag, "_mem_strobes"}, int'({out_mem_read_en, out_mem_write_en}), 0);
    chk({tag, "_mem_address"}, int'(out_mem_address), 0);
    chk({tag, "_config"}, int'(out_config), 0);
    chk({tag, "_indices"}, int'({out_row_index, out_col_index}), 0);
    chk({tag, "_mu"}, int'(out_mu), 0);
  endtask

  initial begin
    int d0, i0, n, cfg;
    for (int k = 0; k < CH; k++) res_q[k] = 1'b0;
    tick(3);
    chk_all_zero("reset");
    in_reset = 1'b1;
    tick(2);

    // Contention from a fresh pointer, plus write-wins on the granted channel.
    in_request = 2'b11;
    tick(1);
    chk("arb_first_ch0", int'(out_grant), 1);
    in_ch_mem_read_en[0] = 1'b1; in_ch_mem_write_en[0] = 1'b1;
    in_ch_mem_address[ML-1:0] = 8'h10; in_ch_mem_data[W-1:0] = 96'hAB;
    #1;
    chk("ww_write_en", int'(out_mem_write_en), 1);
    chk("ww_read_en", int'(out_mem_read_en), 0);
    chk("ww_address", int'(out_mem_address), 'h10);
    chk("ww_data", int'(out_mem_data[31:0]), 'hAB);
    tick(1);
    in_ch_mem_write_en[0] = 1'b0;
    chk("arb_hold_2", int'(out_grant), 1);
    tick(1);
    in_ch_mem_read_en[0] = 1'b0;
    chk("readback", int'(out_ch_mem_data[31:0]), 'hAB);
    chk("arb_hold_3", int'(out_grant), 1);
    tick(1);
    chk("arb_hold_4", int'(out_grant), 1);
    in_request = 2'b10;
    tick(1);
    chk("arb_then_ch1", int'(out_grant), 2);
    in_request = 2'b00;
    tick(1);
    chk("arb_released", int'(out_grant), 0);
    in_request = 2'b11;
    tick(1);
    chk("arb_next_ch0", int'(out_grant), 1);
    in_request = 2'b00;
    tick(2);

    // Directed 3x2 job with fixed 5-cycle channels.
    fixed_lat = 5;
    run_job(32'h0001_0203, 1'b1, 300);

    // lambda == 0: cycle-exact done, no grants while the sequencer reads.
    mem[0] = {64'h0, 32'h0001_0000};
    d0 = n_done; i0 = n_issued;
    in_request = 2'b01;
    pulse_start();
    chk("l0_c1_busy", int'(out_busy), 1);
    chk("l0_c1_read_en", int'(out_mem_read_en), 1);
    chk("l0_c1_address", int'(out_mem_address), 0);
    chk("l0_c1_grant", int'(out_grant), 0);
    tick(1);
    chk("l0_c2_busy", int'(out_busy), 1);
    chk("l0_c2_grant", int'(out_grant), 0);
    chk("l0_c2_done", int'(out_done), 0);
    tick(1);
    chk("l0_c3_done", int'(out_done), 1);
    chk("l0_c3_busy", int'(out_busy), 0);
    tick(1);
    chk("l0_c4_done", int'(out_done), 0);
    in_request = 2'b00;
    tick(2);
    chk("l0_done_count", n_done - d0, 1);
    chk("l0_no_jobs", n_issued - i0, 0);

    // Start pulsed during DRAIN is ignored.
    fixed_lat = 8;
    cfg = 32'h0003_0201;
    mem[0] = {64'h0, 32'(cfg)};
    push_jobs(cfg, 1'b1);
    d0 = n_done; i0 = n_issued;
    pulse_start();
    n = 0;
    while (n_issued - i0 < 2 && n < 100) begin tick(1); n++; end
    chk("drain_reached", n_issued - i0, 2);
    pulse_start();
    wait_done(d0, 100);
    tick(10);
    chk("drain_done_count", n_done - d0, 1);
    chk("drain_busy_after", int'(out_busy), 0);
    exp_q.delete();

    // Asynchronous reset mid-dispatch, then a clean restart.
    fixed_lat = 5;
    cfg = 32'h0001_0203;
    mem[0] = {64'h0, 32'(cfg)};
    push_jobs(cfg, 1'b1);
    i0 = n_issued;
    pulse_start();
    n = 0;
    while (n_issued - i0 < 3 && n < 100) begin tick(1); n++; end
    chk("midreset_progress", n_issued - i0, 3);
    #2 in_reset = 1'b0;
    #1 chk_all_zero("midreset");
    exp_q.delete();
    tick(3);
    in_reset = 1'b1;
    tick(2);
    run_job(cfg, 1'b1, 300);

    // Randomized configs and channel latencies.
    fixed_lat = 0;
    repeat (8) begin
      cfg = int'({8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 4))});
      run_job(cfg, 1'b0, 500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
